alu_regfile_datapath: RTL and testbench



---
 rtl/alu_regfile_datapath.sv | 72 +++++++
 tb/tb_alu_regfile_datapath.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_datapath.sv
// Datapath slice for one core: 32-entry register file feeding an 8-bit ALU.
// Register 0 reads as zero; ALU and zero flag are purely combinational.
module alu_regfile_datapath #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic [2:0]            alucontrol,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOR = 3'b101,
      OP_SLT = 3'b110,
      OP_SLL = 3'b111
   } alu_op_e;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  slt_bit;

   // Reset wins over a same-cycle write; address 0 is never written.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[ADDR_WIDTH'(i)] <= '0;
         end
      end else if (write_enable && (write_reg != '0)) begin
         regs[write_reg] <= write_data;
      end
   end

   always_comb begin
      read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
      read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
   end

   assign slt_bit = ($signed(read_data1) < $signed(read_data2));

   always_comb begin
      result = '0;
      case (alucontrol)
         OP_ADD:  result = read_data1 + read_data2;
         OP_SUB:  result = read_data1 - read_data2;
         OP_AND:  result = read_data1 & read_data2;
         OP_OR:   result = read_data1 | read_data2;
         OP_XOR:  result = read_data1 ^ read_data2;
         OP_NOR:  result = ~(read_data1 | read_data2);
         OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
         OP_SLL:  result = read_data1 << read_data2[2:0];
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Scoreboard bench for alu_regfile_datapath: directed plan cases followed by
// randomized traffic checked against an array-based reference model.
module tb_alu_regfile_datapath;

   localparam int DW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] read_reg1, read_reg2, write_reg;
   logic [DW-1:0] write_data;
   logic          write_enable;
   logic [2:0]    alucontrol;
   logic [DW-1:0] read_data1, read_data2, result;
   logic          zero;

   typedef struct {
      int rd1;
      int rd2;
      int res;
      int z;
      int id;
   } exp_t;

   exp_t scb[$];
   int   model[32];
   int   checks = 0;
   int   errors = 0;
   int   n_id   = 0;

   always #5 clk = ~clk;

   alu_regfile_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk),
      .reset(reset),
      .read_reg1(read_reg1),
      .read_reg2(read_reg2),
      .write_reg(write_reg),
      .write_data(write_data),
      .write_enable(write_enable),
      .alucontrol(alucontrol),
      .read_data1(read_data1),
      .read_data2(read_data2),
      .result(result),
      .zero(zero)
   );

   function automatic int to_signed8(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   function automatic int alu_ref(input int op, input int a, input int b);
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 255 - (a | b);
         6: return (to_signed8(a) < to_signed8(b)) ? 1 : 0;
         7: return (a * (1 << (b % 8))) % 256;
         default: return 0;
      endcase
   endfunction

   // Drive one cycle of inputs; expected outputs reflect state before the coming edge.
   task automatic step(input bit rst_n, input bit we, input int wr, input int wd,
                       input int r1, input int r2, input int op, input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      reset        = rst_n;
      write_enable = we;
      write_reg    = AW'(wr);
      write_data   = DW'(wd);
      read_reg1    = AW'(r1);
      read_reg2    = AW'(r2);
      alucontrol   = 3'(op);
      if (chk) begin
         e.rd1 = model[r1];
         e.rd2 = model[r2];
         e.res = alu_ref(op, e.rd1, e.rd2);
         e.z   = (e.res == 0) ? 1 : 0;
         e.id  = n_id;
         n_id++;
         scb.push_back(e);
      end
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 0;
      end else if (we && wr != 0) begin
         model[wr] = wd;
      end
   endtask

   task automatic compare(input string name, input int id, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s txn %0d: got %0d expected %0d", name, id, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (scb.size() > 0) begin
         e = scb.pop_front();
         compare("read_data1", e.id, int'(read_data1), e.rd1);
         compare("read_data2", e.id, int'(read_data2), e.rd2);
         compare("result",     e.id, int'(result),     e.res);
         compare("zero",       e.id, int'(zero),       e.z);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 0;
      reset = 1'b0; write_enable = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = '0; read_reg2 = '0; alucontrol = '0;

      // Reset, then sweep every address on both ports.
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 7, 99, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) step(1, 0, 0, 0, i, 31 - i, 0, 1);

      // Write/add and write-back.
      step(1, 1, 1, 94, 0, 0, 0, 0);
      step(1, 1, 2, 12, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 2, 0, 1);
      step(1, 1, 3, 106, 1, 2, 0, 1);
      step(1, 0, 0, 0, 3, 0, 0, 1);

      // All ops on r1/r2, then swapped sub and slt.
      for (int op = 0; op < 8; op++) step(1, 0, 0, 0, 1, 2, op, 1);
      step(1, 0, 0, 0, 2, 1, 1, 1);
      step(1, 0, 0, 0, 2, 1, 6, 1);

      // Boundaries: wrap to zero, signed slt, r0 write, disabled write.
      step(1, 1, 4, 255, 0, 0, 0, 0);
      step(1, 1, 5, 1, 0, 0, 0, 0);
      step(1, 1, 6, 128, 4, 5, 0, 1);
      step(1, 0, 0, 0, 6, 5, 6, 1);
      step(1, 1, 0, 55, 0, 0, 0, 1);
      step(1, 0, 1, 77, 0, 0, 3, 1);
      step(1, 0, 0, 0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1, 7, 1);

      // Reset beats a same-cycle write to r1.
      step(0, 1, 1, 200, 1, 2, 0, 1);
      step(1, 0, 0, 0, 1, 2, 0, 1);

      // Randomized traffic with occasional mid-sequence resets.
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 59) != 0), $urandom_range(0, 1),
              $urandom_range(0, 31), $urandom_range(0, 255),
              $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 7), 1);
      end

      // Fill everything, reset mid-sequence, confirm all cleared.
      for (int i = 1; i < 32; i++) step(1, 1, i, (i * 37 + 5) % 256, i, 0, 0, 1);
      step(0, 0, 0, 0, 31, 30, 4, 1);
      for (int i = 0; i < 32; i++) step(1, 0, 0, 0, i, (i + 1) % 32, 0, 1);

      for (int k = 0; k < 10 && scb.size() > 0; k++) @(posedge clk);
      if (scb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", scb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
